// File: rtl/tl_tx_arb.sv
// Transaction-layer transmit arbiter: P/NP/CPL header arbitration with credit
// checks, round-robin plus starvation override, and a one-entry output register.
module tl_tx_arb #(
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned HDR_CRED_W  = 8,
  parameter int unsigned DATA_CRED_W = 12,
  parameter int unsigned STARVE_MAX  = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  // posted
  input  logic [127:0]           p_hdr_i,
  input  logic [LEN_W-1:0]       p_len_i,
  input  logic                   p_valid_i,
  output logic                   p_ready_o,
  input  logic [HDR_CRED_W-1:0]  p_hdr_cred_i,
  input  logic [DATA_CRED_W-1:0] p_data_cred_i,
  output logic                   p_cred_consume_o,
  // non-posted
  input  logic [127:0]           np_hdr_i,
  input  logic [LEN_W-1:0]       np_len_i,
  input  logic                   np_valid_i,
  output logic                   np_ready_o,
  input  logic [HDR_CRED_W-1:0]  np_hdr_cred_i,
  input  logic [DATA_CRED_W-1:0] np_data_cred_i,
  output logic                   np_cred_consume_o,
  // completion
  input  logic [127:0]           cpl_hdr_i,
  input  logic [LEN_W-1:0]       cpl_len_i,
  input  logic                   cpl_valid_i,
  output logic                   cpl_ready_o,
  input  logic [HDR_CRED_W-1:0]  cpl_hdr_cred_i,
  input  logic [DATA_CRED_W-1:0] cpl_data_cred_i,
  output logic                   cpl_cred_consume_o,
  // credit consume amount and link-side output
  output logic [DATA_CRED_W-1:0] cred_data_o,
  output logic [127:0]           tx_hdr_o,
  output logic [LEN_W-1:0]       tx_len_o,
  output logic [1:0]             tx_class_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i
);

  localparam int unsigned NCLS    = 3;
  localparam int unsigned DNEED_W = LEN_W + 1;
  localparam int unsigned CMP_W   = (DNEED_W > DATA_CRED_W) ? DNEED_W : DATA_CRED_W;
  localparam int unsigned SW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  localparam logic [1:0] CLS_P   = 2'd0;
  localparam logic [1:0] CLS_NP  = 2'd1;
  localparam logic [1:0] CLS_CPL = 2'd2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // per-class views of the request ports, index 0=P, 1=NP, 2=CPL
  logic [NCLS-1:0]        valid;
  logic [HDR_CRED_W-1:0]  hdr_cred  [NCLS];
  logic [DATA_CRED_W-1:0] data_cred [NCLS];
  logic [LEN_W-1:0]       len       [NCLS];
  logic [DNEED_W-1:0]     dneed     [NCLS];

  assign valid        = {cpl_valid_i, np_valid_i, p_valid_i};
  assign hdr_cred[0]  = p_hdr_cred_i;
  assign hdr_cred[1]  = np_hdr_cred_i;
  assign hdr_cred[2]  = cpl_hdr_cred_i;
  assign data_cred[0] = p_data_cred_i;
  assign data_cred[1] = np_data_cred_i;
  assign data_cred[2] = cpl_data_cred_i;
  assign len[0]       = p_len_i;
  assign len[1]       = np_len_i;
  assign len[2]       = cpl_len_i;

  // state
  state_t                  state_q, state_d;
  logic [1:0]              ptr_q, ptr_d;
  logic [NCLS-1:0][SW-1:0] starve_q, starve_d;
  logic [NCLS-1:0]         cons_q, cons_d;
  logic [DATA_CRED_W-1:0]  cred_data_q, cred_data_d;
  logic [127:0]            tx_hdr_q, tx_hdr_d;
  logic [LEN_W-1:0]        tx_len_q, tx_len_d;
  logic [1:0]              tx_class_q, tx_class_d;

  // combinational arbitration results
  logic [NCLS-1:0]         elig;
  logic [NCLS-1:0]         starve_hit;
  logic                    any_elig;
  logic                    load;
  logic [1:0]              rr_win;
  logic [1:0]              win;
  logic [NCLS-1:0]         ready_c;
  logic [DNEED_W-1:0]      win_dneed;
  logic [127:0]            win_hdr;
  logic [LEN_W-1:0]        win_len;

  // data-credit need, eligibility and starvation hits per class
  always_comb begin
    elig       = '0;
    starve_hit = '0;
    for (int unsigned i = 0; i < NCLS; i++) begin
      dneed[i] = (DNEED_W'(len[i]) + DNEED_W'(3)) >> 2;
      // a class granted last cycle is blocked: its credit count is still stale
      elig[i] = valid[i] && (hdr_cred[i] != '0) &&
                (CMP_W'(data_cred[i]) >= CMP_W'(dneed[i])) && !cons_q[i];
      starve_hit[i] = elig[i] && (starve_q[i] == SW'(STARVE_MAX));
    end
    any_elig = |elig;
  end

  // winner selection: starved classes first (P>NP>CPL), else round-robin after ptr
  always_comb begin
    rr_win = CLS_P;
    win    = CLS_P;
    case (ptr_q)
      CLS_P:   rr_win = elig[1] ? CLS_NP  : (elig[2] ? CLS_CPL : CLS_P);
      CLS_NP:  rr_win = elig[2] ? CLS_CPL : (elig[0] ? CLS_P   : CLS_NP);
      default: rr_win = elig[0] ? CLS_P   : (elig[1] ? CLS_NP  : CLS_CPL);
    endcase
    if (starve_hit[0])      win = CLS_P;
    else if (starve_hit[1]) win = CLS_NP;
    else if (starve_hit[2]) win = CLS_CPL;
    else                    win = rr_win;
  end

  // winner payload mux
  always_comb begin
    win_dneed = dneed[0];
    win_hdr   = p_hdr_i;
    win_len   = p_len_i;
    case (win)
      CLS_NP: begin
        win_dneed = dneed[1];
        win_hdr   = np_hdr_i;
        win_len   = np_len_i;
      end
      CLS_CPL: begin
        win_dneed = dneed[2];
        win_hdr   = cpl_hdr_i;
        win_len   = cpl_len_i;
      end
      default: ;
    endcase
  end

  // FSM next state, load decision, grant strobes and register next values
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    starve_d    = starve_q;
    cons_d      = '0;
    cred_data_d = '0;
    tx_hdr_d    = tx_hdr_q;
    tx_len_d    = tx_len_q;
    tx_class_d  = tx_class_q;
    ready_c     = '0;

    // rst_n gating keeps every grant strobe low while reset is held
    load = rst_n && any_elig && ((state_q == S_IDLE) || tx_ready_i);

    case (state_q)
      S_IDLE:  if (load) state_d = S_SEND;
      S_SEND:  if (tx_ready_i && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      ready_c[win] = 1'b1;
      cons_d[win]  = 1'b1;
      cred_data_d  = DATA_CRED_W'(win_dneed);
      tx_hdr_d     = win_hdr;
      tx_len_d     = win_len;
      tx_class_d   = win;
      ptr_d        = win;
    end

    for (int unsigned i = 0; i < NCLS; i++) begin
      if (!valid[i] || (load && (win == 2'(i)))) begin
        starve_d[i] = '0;
      end else if (load && (starve_q[i] != SW'(STARVE_MAX))) begin
        starve_d[i] = starve_q[i] + SW'(1);
      end
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= CLS_CPL;
      starve_q    <= '0;
      cons_q      <= '0;
      cred_data_q <= '0;
      tx_hdr_q    <= '0;
      tx_len_q    <= '0;
      tx_class_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      starve_q    <= starve_d;
      cons_q      <= cons_d;
      cred_data_q <= cred_data_d;
      tx_hdr_q    <= tx_hdr_d;
      tx_len_q    <= tx_len_d;
      tx_class_q  <= tx_class_d;
    end
  end

  assign p_ready_o          = ready_c[0];
  assign np_ready_o         = ready_c[1];
  assign cpl_ready_o        = ready_c[2];
  assign p_cred_consume_o   = cons_q[0];
  assign np_cred_consume_o  = cons_q[1];
  assign cpl_cred_consume_o = cons_q[2];
  assign cred_data_o        = cred_data_q;
  assign tx_hdr_o           = tx_hdr_q;
  assign tx_len_o           = tx_len_q;
  assign tx_class_o         = tx_class_q;
  assign tx_valid_o         = (state_q == S_SEND);

endmodule

// File: tb/tb_tl_tx_arb.sv
// Directed self-checking bench for tl_tx_arb.
module tb_tl_tx_arb;

  localparam int unsigned LEN_W       = 10;
  localparam int unsigned HDR_CRED_W  = 8;
  localparam int unsigned DATA_CRED_W = 12;

  localparam logic [127:0] HDR_P   = 128'h1111_0000_0000_0000_0000_0000_0000_00a1;
  localparam logic [127:0] HDR_NP  = 128'h2222_0000_0000_0000_0000_0000_0000_00b2;
  localparam logic [127:0] HDR_CPL = 128'h3333_0000_0000_0000_0000_0000_0000_00c3;

  logic                   clk;
  logic                   rst_n;
  logic [127:0]           p_hdr_i, np_hdr_i, cpl_hdr_i;
  logic [LEN_W-1:0]       p_len_i, np_len_i, cpl_len_i;
  logic                   p_valid_i, np_valid_i, cpl_valid_i;
  logic                   p_ready_o, np_ready_o, cpl_ready_o;
  logic [HDR_CRED_W-1:0]  p_hdr_cred_i, np_hdr_cred_i, cpl_hdr_cred_i;
  logic [DATA_CRED_W-1:0] p_data_cred_i, np_data_cred_i, cpl_data_cred_i;
  logic                   p_cred_consume_o, np_cred_consume_o, cpl_cred_consume_o;
  logic [DATA_CRED_W-1:0] cred_data_o;
  logic [127:0]           tx_hdr_o;
  logic [LEN_W-1:0]       tx_len_o;
  logic [1:0]             tx_class_o;
  logic                   tx_valid_o;
  logic                   tx_ready_i;

  int n_checks;
  int n_errors;

  tl_tx_arb dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .p_hdr_i            (p_hdr_i),
    .p_len_i            (p_len_i),
    .p_valid_i          (p_valid_i),
    .p_ready_o          (p_ready_o),
    .p_hdr_cred_i       (p_hdr_cred_i),
    .p_data_cred_i      (p_data_cred_i),
    .p_cred_consume_o   (p_cred_consume_o),
    .np_hdr_i           (np_hdr_i),
    .np_len_i           (np_len_i),
    .np_valid_i         (np_valid_i),
    .np_ready_o         (np_ready_o),
    .np_hdr_cred_i      (np_hdr_cred_i),
    .np_data_cred_i     (np_data_cred_i),
    .np_cred_consume_o  (np_cred_consume_o),
    .cpl_hdr_i          (cpl_hdr_i),
    .cpl_len_i          (cpl_len_i),
    .cpl_valid_i        (cpl_valid_i),
    .cpl_ready_o        (cpl_ready_o),
    .cpl_hdr_cred_i     (cpl_hdr_cred_i),
    .cpl_data_cred_i    (cpl_data_cred_i),
    .cpl_cred_consume_o (cpl_cred_consume_o),
    .cred_data_o        (cred_data_o),
    .tx_hdr_o           (tx_hdr_o),
    .tx_len_o           (tx_len_o),
    .tx_class_o         (tx_class_o),
    .tx_valid_o         (tx_valid_o),
    .tx_ready_i         (tx_ready_i)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ready_vec();
    return {cpl_ready_o, np_ready_o, p_ready_o};
  endfunction

  function automatic logic [2:0] cons_vec();
    return {cpl_cred_consume_o, np_cred_consume_o, p_cred_consume_o};
  endfunction

  // round-robin expectation tables: class, one-hot, credits (P len5->2, NP len12->3, CPL len8->2)
  logic [1:0]  rr_cls  [6];
  logic [2:0]  rr_oh   [6];
  logic [11:0] rr_cred [6];
  logic [127:0] rr_hdr [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rr_cls  = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    rr_oh   = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_cred = '{12'd2, 12'd3, 12'd2, 12'd2, 12'd3, 12'd2};
    rr_hdr  = '{HDR_P, HDR_NP, HDR_CPL, HDR_P, HDR_NP, HDR_CPL};

    rst_n = 1'b0;
    p_hdr_i = HDR_P;   np_hdr_i = HDR_NP;   cpl_hdr_i = HDR_CPL;
    p_len_i = 10'd5;   np_len_i = 10'd12;   cpl_len_i = 10'd8;
    p_valid_i = 1'b0;  np_valid_i = 1'b0;   cpl_valid_i = 1'b0;
    p_hdr_cred_i = 8'd4; np_hdr_cred_i = 8'd4; cpl_hdr_cred_i = 8'd4;
    p_data_cred_i = 12'd100; np_data_cred_i = 12'd100; cpl_data_cred_i = 12'd100;
    tx_ready_i = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 128'(tx_valid_o), 128'(0));
    check("rst_tx_hdr", tx_hdr_o, 128'(0));
    check("rst_tx_len", 128'(tx_len_o), 128'(0));
    check("rst_tx_class", 128'(tx_class_o), 128'(0));
    check("rst_cons", 128'(cons_vec()), 128'(0));
    check("rst_cred_data", 128'(cred_data_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single P request: len 5 needs 2 data credits
    p_valid_i = 1'b1; p_hdr_cred_i = 8'd1; p_data_cred_i = 12'd2;
    @(negedge clk);
    check("single_ready", 128'(ready_vec()), 128'(3'b001));
    tick();
    check("single_tx_valid", 128'(tx_valid_o), 128'(1));
    check("single_tx_class", 128'(tx_class_o), 128'(0));
    check("single_tx_hdr", tx_hdr_o, HDR_P);
    check("single_tx_len", 128'(tx_len_o), 128'(5));
    check("single_cons", 128'(cons_vec()), 128'(3'b001));
    check("single_cred_data", 128'(cred_data_o), 128'(2));
    p_valid_i = 1'b0;
    tick();
    check("single_idle_valid", 128'(tx_valid_o), 128'(0));
    check("single_idle_cons", 128'(cons_vec()), 128'(0));
    check("single_idle_cred", 128'(cred_data_o), 128'(0));

    // data-credit boundary: 1 credit is short of 2
    p_valid_i = 1'b1; p_data_cred_i = 12'd1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("dcred_short_ready", 128'(ready_vec()), 128'(0));
      tick();
    end
    check("dcred_short_valid", 128'(tx_valid_o), 128'(0));
    p_data_cred_i = 12'd2;
    @(negedge clk);
    check("dcred_ok_ready", 128'(ready_vec()), 128'(3'b001));
    tick();
    check("dcred_ok_valid", 128'(tx_valid_o), 128'(1));
    check("dcred_ok_cons", 128'(cons_vec()), 128'(3'b001));
    check("dcred_ok_cred", 128'(cred_data_o), 128'(2));
    p_valid_i = 1'b0;
    p_hdr_cred_i = 8'd4; p_data_cred_i = 12'd100;
    tick();

    // reset mid-transfer with requests pending
    p_valid_i = 1'b1;
    tick();
    check("pre_rst_valid", 128'(tx_valid_o), 128'(1));
    tx_ready_i = 1'b0;
    np_valid_i = 1'b1; cpl_valid_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", 128'(tx_valid_o), 128'(0));
    check("midrst_cons", 128'(cons_vec()), 128'(0));
    check("midrst_ready", 128'(ready_vec()), 128'(0));
    check("midrst_hdr", tx_hdr_o, 128'(0));
    p_valid_i = 1'b0; np_valid_i = 1'b0; cpl_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready_i = 1'b1;
    tick();

    // round-robin with all classes valid: P, NP, CPL, P, NP, CPL
    p_valid_i = 1'b1; np_valid_i = 1'b1; cpl_valid_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("rr_ready", 128'(ready_vec()), 128'(rr_oh[k]));
      tick();
      check("rr_tx_valid", 128'(tx_valid_o), 128'(1));
      check("rr_tx_class", 128'(tx_class_o), 128'(rr_cls[k]));
      check("rr_tx_hdr", tx_hdr_o, rr_hdr[k]);
      check("rr_cons", 128'(cons_vec()), 128'(rr_oh[k]));
      check("rr_cred", 128'(cred_data_o), 128'(rr_cred[k]));
    end

    // backpressure: CPL header held for 4 cycles
    tx_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_ready", 128'(ready_vec()), 128'(0));
      tick();
      check("bp_tx_valid", 128'(tx_valid_o), 128'(1));
      check("bp_tx_class", 128'(tx_class_o), 128'(2));
      check("bp_tx_hdr", tx_hdr_o, HDR_CPL);
      check("bp_tx_len", 128'(tx_len_o), 128'(8));
      check("bp_cons", 128'(cons_vec()), 128'(0));
    end
    p_valid_i = 1'b0; np_valid_i = 1'b0; cpl_valid_i = 1'b0;
    tx_ready_i = 1'b1;
    tick();
    check("bp_drain_valid", 128'(tx_valid_o), 128'(0));

    // starvation: NP blocked on header credits while P and CPL alternate
    np_hdr_cred_i = 8'd0;
    p_valid_i = 1'b1; np_valid_i = 1'b1; cpl_valid_i = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("starve_alt_ready", 128'(ready_vec()), 128'((k % 2 == 0) ? 3'b001 : 3'b100));
      tick();
    end
    check("starve_cnt_max", 128'(dut.starve_q[1]), 128'(15));
    np_hdr_cred_i = 8'd1;
    @(negedge clk);
    check("starve_np_ready", 128'(ready_vec()), 128'(3'b010));
    tick();
    check("starve_tx_class", 128'(tx_class_o), 128'(1));
    check("starve_cons", 128'(cons_vec()), 128'(3'b010));
    check("starve_cred", 128'(cred_data_o), 128'(3));
    check("starve_cnt_clr", 128'(dut.starve_q[1]), 128'(0));

    p_valid_i = 1'b0; np_valid_i = 1'b0; cpl_valid_i = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
